// File: rtl/imem_loader.sv
// imem_loader: unpacks a framed byte stream into 32-bit imem writes and holds the
// CPU in reset until a checksum-valid image has been loaded.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              rearm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  typedef enum logic [2:0] {INIT, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR} state_t;
  // Words available from BASE_ADDR to the top of memory, compared at full width.
  localparam logic [31:0] LIMIT = (32'd1 << ADDR_W) - 32'(BASE_ADDR);
  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       n_q, n_d;
  logic [17:0]       cnt_q, cnt_d;
  logic [7:0]        xor_q, xor_d;
  logic [23:0]       sh_q, sh_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              xfer;
  logic [15:0]       n_in;
  assign byte_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                      (state_q == DATA) || (state_q == CSUM);
  assign cpu_hold   = state_q != DONE;
  assign done       = state_q == DONE;
  assign error      = state_q == ERROR;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign xfer       = byte_valid & byte_ready;
  assign n_in       = {len_hi_q, byte_in};
  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    xor_d     = xor_q;
    sh_d      = sh_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      INIT: begin
        state_d = LEN_HI;
        cnt_d   = '0;
        xor_d   = '0;
      end
      LEN_HI: if (xfer) begin
        len_hi_d = byte_in;
        state_d  = LEN_LO;
      end
      LEN_LO: if (xfer) begin
        n_d     = n_in;
        state_d = (n_in == 16'd0 || 32'(n_in) > LIMIT) ? ERROR : DATA;
      end
      DATA: if (xfer) begin
        cnt_d = cnt_q + 18'd1;
        xor_d = xor_q ^ byte_in;
        sh_d  = {sh_q[15:0], byte_in};
        if (cnt_q[1:0] == 2'd3) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_W'(32'(BASE_ADDR) + 32'(cnt_q[17:2]));
          wr_data_d = {sh_q, byte_in};
        end
        if (cnt_d == {n_q, 2'b00}) state_d = CSUM;
      end
      CSUM: if (xfer) state_d = (byte_in == xor_q) ? DONE : ERROR;
      default: if (rearm) state_d = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= INIT;
      len_hi_q  <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      xor_q     <= '0;
      sh_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      xor_q     <= xor_d;
      sh_q      <= sh_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames against a frame-position model of the loader,
// checked every cycle, plus literal expectations on the resulting memory image.
module tb_imem_loader;
  localparam int DEPTH = 256;
  localparam int BASE = 0;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        rearm = 1'b0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  int checks = 0;
  int failures = 0;
  imem_loader #(.ADDR_W(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .rearm(rearm), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: status 0=init 1=loading 2=done 3=error; pos counts consumed frame bytes.
  int          m_st = 0;
  int          m_pos = 0;
  int          m_n = 0;
  int          p;
  logic [7:0]  m_hi = 0;
  logic [7:0]  m_x = 0;
  logic [31:0] m_w = 0;
  logic        e_we = 0;
  int          e_addr = 0;
  logic [31:0] e_data = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_st = 0; m_pos = 0; m_x = 0; e_we = 0; e_addr = 0; e_data = 0;
    end else begin
      e_we = 0;
      if (m_st == 0) begin
        m_st = 1; m_pos = 0; m_x = 0;
      end else if (m_st == 1) begin
        if (byte_valid) begin
          if (m_pos == 0) m_hi = byte_in;
          else if (m_pos == 1) begin
            m_n = {16'd0, m_hi, byte_in};
            if (m_n == 0 || m_n > DEPTH - BASE) m_st = 3;
          end else if (m_pos < 4 * m_n + 2) begin
            p = m_pos - 2;
            m_x ^= byte_in;
            m_w = {m_w[23:0], byte_in};
            if (p % 4 == 3) begin e_we = 1; e_addr = BASE + p / 4; e_data = m_w; end
          end else m_st = (byte_in == m_x) ? 2 : 3;
          m_pos++;
        end
      end else if (rearm) m_st = 0;
    end
  end
  logic [31:0] mem [0:DEPTH-1];
  int wcount = 0;
  always @(negedge clk) begin
    chk("byte_ready", 32'(byte_ready), 32'(m_st == 1));
    chk("cpu_hold", 32'(cpu_hold), 32'(m_st != 2));
    chk("done", 32'(done), 32'(m_st == 2));
    chk("error", 32'(error), 32'(m_st == 3));
    chk("wr_en", 32'(wr_en), 32'(e_we));
    chk("wr_addr", 32'(wr_addr), 32'(e_addr));
    chk("wr_data", wr_data, e_data);
    if (wr_en) begin mem[wr_addr] = wr_data; wcount++; end
  end
  logic [7:0] fr[$];
  task automatic send(input bit stall);
    int t;
    for (int i = 0; i < fr.size(); i++) begin
      if (stall) begin
        byte_valid = 1'b0; byte_in = 8'hFF;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      byte_valid = 1'b1; byte_in = fr[i];
      t = 0;
      while (!byte_ready && t < 20) begin @(negedge clk); t++; end
      if (!byte_ready) begin
        checks++; failures++;
        $display("FAIL ready_timeout: byte %0d never accepted", i);
        break;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask
  task automatic t1(input logic [7:0] cs);
    fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, cs};
  endtask
  task automatic pulse_rearm();
    rearm = 1'b1; @(negedge clk); rearm = 1'b0; @(negedge clk);
  endtask
  initial begin
    int w0;
    logic [7:0] b, x;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(byte_ready), 0);
    chk("rst_hold", 32'(cpu_hold), 1);
    chk("rst_wr_en", 32'(wr_en), 0);
    reset = 1'b1;
    @(negedge clk);
    // Nominal two-word image
    t1(8'h0E); w0 = wcount; send(0); repeat (2) @(negedge clk);
    chk("t1_done", 32'(done), 1);
    chk("t1_hold", 32'(cpu_hold), 0);
    chk("t1_mem0", mem[0], 32'h20080005);
    chk("t1_mem1", mem[1], 32'h2009000A);
    chk("t1_writes", 32'(wcount - w0), 2);
    // Rearm, single word
    pulse_rearm();
    chk("t6_hold", 32'(cpu_hold), 1);
    chk("t6_done", 32'(done), 0);
    fr = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    w0 = wcount; send(0); repeat (2) @(negedge clk);
    chk("t6_mem0", mem[0], 32'hDEADBEEF);
    chk("t6_done2", 32'(done), 1);
    chk("t6_writes", 32'(wcount - w0), 1);
    // Bad checksum
    pulse_rearm();
    t1(8'h0F); w0 = wcount; send(0); repeat (2) @(negedge clk);
    chk("t2_error", 32'(error), 1);
    chk("t2_hold", 32'(cpu_hold), 1);
    chk("t2_ready", 32'(byte_ready), 0);
    chk("t2_writes", 32'(wcount - w0), 2);
    // Zero and oversize lengths
    pulse_rearm();
    fr = '{8'h00, 8'h00}; w0 = wcount; send(0); @(negedge clk);
    chk("t3_zero_err", 32'(error), 1);
    pulse_rearm();
    fr = '{8'h01, 8'h01}; send(0); @(negedge clk);
    chk("t3_big_err", 32'(error), 1);
    chk("t3_writes", 32'(wcount - w0), 0);
    // Stalled stream
    pulse_rearm();
    mem[0] = 0; mem[1] = 0;
    t1(8'h0E); w0 = wcount; send(1); repeat (2) @(negedge clk);
    chk("t4_done", 32'(done), 1);
    chk("t4_mem0", mem[0], 32'h20080005);
    chk("t4_mem1", mem[1], 32'h2009000A);
    chk("t4_writes", 32'(wcount - w0), 2);
    // Async reset mid-frame
    pulse_rearm();
    t1(8'h0E); fr = fr[0:6]; w0 = wcount; send(0);
    #2 reset = 1'b0;
    #1;
    chk("t5_ready", 32'(byte_ready), 0);
    chk("t5_hold", 32'(cpu_hold), 1);
    chk("t5_wr_addr", 32'(wr_addr), 0);
    chk("t5_wr_data", wr_data, 0);
    chk("t5_done", 32'(done), 0);
    @(negedge clk); reset = 1'b1; @(negedge clk);
    chk("t5_writes", 32'(wcount - w0), 1);
    t1(8'h0E); send(0); repeat (2) @(negedge clk);
    chk("t5_done2", 32'(done), 1);
    // Full-depth image reaching the top address
    pulse_rearm();
    fr = '{8'h01, 8'h00}; x = 0;
    for (int i = 0; i < 1024; i++) begin b = 8'(i * 7 + 3); fr.push_back(b); x ^= b; end
    fr.push_back(x);
    w0 = wcount; send(0); repeat (2) @(negedge clk);
    chk("full_done", 32'(done), 1);
    chk("full_writes", 32'(wcount - w0), 256);
    chk("full_mem255", mem[255], 32'hE7EEF5FC);
    chk("full_mem0", mem[0], 32'h030A1118);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
